// File: rtl/donesync_pkg.sv
// Shared types and defaults for the sampler-to-top completion synchronizer.
package donesync_pkg;

    localparam int COUNT_W_DEF = 16;
    localparam int FIFO_AW_DEF = 2;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_REL  = 2'd2
    } state_e;

endpackage

// File: rtl/donesync_if.sv
// Completion-report signals between the sampler core, donesync and the top domain.
interface donesync_if
    import donesync_pkg::*;
#(
    parameter int COUNT_W = COUNT_W_DEF
);
    logic               sampler_donesync_done;
    logic [COUNT_W-1:0] sampler_donesync_count;
    logic               samplertop_donesync_ack;
    logic               donesync_samplertop_req;
    logic [COUNT_W-1:0] donesync_samplertop_count;
    logic               donesync_sampler_busy;
    logic               donesync_sampler_overflow;

    modport slave (
        input  sampler_donesync_done,
        input  sampler_donesync_count,
        input  samplertop_donesync_ack,
        output donesync_samplertop_req,
        output donesync_samplertop_count,
        output donesync_sampler_busy,
        output donesync_sampler_overflow
    );

    modport master (
        output sampler_donesync_done,
        output sampler_donesync_count,
        output samplertop_donesync_ack,
        input  donesync_samplertop_req,
        input  donesync_samplertop_count,
        input  donesync_sampler_busy,
        input  donesync_sampler_overflow
    );
endinterface

// File: rtl/donesync_fifo.sv
// Report queue: synchronous FIFO whose pointers carry an extra wrap bit.
module donesync_fifo #(
    parameter int W  = 16,
    parameter int AW = 2
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         push_i,
    input  logic [W-1:0] data_i,
    input  logic         pop_i,
    output logic [W-1:0] data_o,
    output logic         full_o,
    output logic         empty_o
);
    localparam int DEPTH = 1 << AW;

    logic [AW:0]  wr_ptr_q;
    logic [AW:0]  rd_ptr_q;
    logic [W-1:0] mem_q [DEPTH];
    logic         do_push;
    logic         do_pop;

    assign empty_o = (wr_ptr_q == rd_ptr_q);
    assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                     (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign do_pop  = pop_i && !empty_o;
    // A pop in the same cycle frees a slot, so a push into a full queue still lands.
    assign do_push = push_i && (!full_o || do_pop);
    assign data_o  = mem_q[rd_ptr_q[AW-1:0]];

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + (AW+1)'(1);
            if (do_pop)  rd_ptr_q <= rd_ptr_q + (AW+1)'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= data_i;
    end
endmodule

// File: rtl/donesync.sv
// Queues capture-done reports and sends each to the top domain over a four-phase req/ack handshake.
module donesync
    import donesync_pkg::*;
#(
    parameter int COUNT_W = COUNT_W_DEF,
    parameter int FIFO_AW = FIFO_AW_DEF
) (
    input  logic      clk_sampler,
    input  logic      rst_sampler_sync,
    donesync_if.slave bus
);
    state_e             state_q;
    logic               req_q;
    logic [COUNT_W-1:0] count_q;
    logic               overflow_q;
    logic               ack_m_q;
    logic               ack_s_q;

    logic [COUNT_W-1:0] fifo_data;
    logic               fifo_full;
    logic               fifo_empty;
    logic               pop;
    logic               drop;

    // Gating on ack_s keeps a stuck-high ack from starting a new report.
    assign pop  = (state_q == ST_IDLE) && !fifo_empty && !ack_s_q;
    assign drop = bus.sampler_donesync_done && fifo_full && !pop;

    donesync_fifo #(
        .W  (COUNT_W),
        .AW (FIFO_AW)
    ) u_fifo (
        .clk_i   (clk_sampler),
        .rst_i   (rst_sampler_sync),
        .push_i  (bus.sampler_donesync_done),
        .data_i  (bus.sampler_donesync_count),
        .pop_i   (pop),
        .data_o  (fifo_data),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    always_ff @(posedge clk_sampler or posedge rst_sampler_sync) begin
        if (rst_sampler_sync) begin
            ack_m_q <= 1'b0;
            ack_s_q <= 1'b0;
        end else begin
            ack_m_q <= bus.samplertop_donesync_ack;
            ack_s_q <= ack_m_q;
        end
    end

    always_ff @(posedge clk_sampler or posedge rst_sampler_sync) begin
        if (rst_sampler_sync) begin
            state_q    <= ST_IDLE;
            req_q      <= 1'b0;
            count_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            if (drop) overflow_q <= 1'b1;
            case (state_q)
                ST_IDLE: begin
                    if (pop) begin
                        count_q <= fifo_data;
                        req_q   <= 1'b1;
                        state_q <= ST_REQ;
                    end
                end
                ST_REQ: begin
                    if (ack_s_q) begin
                        req_q   <= 1'b0;
                        state_q <= ST_REL;
                    end
                end
                ST_REL: begin
                    if (!ack_s_q) state_q <= ST_IDLE;
                end
                default: begin
                    req_q   <= 1'b0;
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.donesync_samplertop_req   = req_q;
    assign bus.donesync_samplertop_count = count_q;
    assign bus.donesync_sampler_overflow = overflow_q;
    assign bus.donesync_sampler_busy     = (state_q != ST_IDLE) || !fifo_empty;
endmodule

// File: tb/tb_donesync.sv
// Self-checking bench for donesync: cycle table, handshake corner sequences, random loopback traffic.
module tb_donesync;
    localparam int CW = 16;

    logic clk_sampler = 1'b0;
    logic clk_top     = 1'b0;
    logic rst         = 1'b1;

    always #5 clk_sampler = ~clk_sampler;
    always #7 clk_top     = ~clk_top;

    donesync_if #(.COUNT_W(CW)) bus();

    donesync #(.COUNT_W(CW), .FIFO_AW(2)) dut (
        .clk_sampler      (clk_sampler),
        .rst_sampler_sync (rst),
        .bus              (bus)
    );

    logic loopback = 1'b0;
    logic ack_man  = 1'b0;
    logic top_m    = 1'b0;
    logic top_s    = 1'b0;
    logic top_s_d  = 1'b0;
    logic [CW-1:0] got_q[$];

    assign bus.samplertop_donesync_ack = loopback ? top_s : ack_man;

    // Top-domain side: 2-flop req synchronizer whose output is the ack; payload taken on synced req rise.
    always @(posedge clk_top) begin
        top_m   <= bus.donesync_samplertop_req;
        top_s   <= top_m;
        top_s_d <= top_s;
        if (loopback && top_s && !top_s_d) got_q.push_back(bus.donesync_samplertop_count);
    end

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    typedef struct {
        logic          done;
        logic [CW-1:0] cnt;
        logic          ack;
        logic          req;
        logic [CW-1:0] ocnt;
        logic          busy;
    } vec_t;

    vec_t tbl[10];

    task automatic pulse_seq(input int n, input logic [CW-1:0] base);
        for (int i = 0; i < n; i++) begin
            @(negedge clk_sampler);
            bus.sampler_donesync_done  = 1'b1;
            bus.sampler_donesync_count = base + CW'(i);
        end
        @(negedge clk_sampler);
        bus.sampler_donesync_done = 1'b0;
    endtask

    task automatic serve(output logic [CW-1:0] c, output bit ok);
        ok = 1'b0;
        c  = '0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk_sampler);
            if (bus.donesync_samplertop_req) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) return;
        c       = bus.donesync_samplertop_count;
        ack_man = 1'b1;
        ok      = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk_sampler);
            if (!bus.donesync_samplertop_req) begin
                ok = 1'b1;
                break;
            end
        end
        ack_man = 1'b0;
    endtask

    task automatic serve_expect(input string name, input logic [CW-1:0] exp);
        logic [CW-1:0] c;
        bit ok;
        serve(c, ok);
        chk({name, "_handshake_done"}, 32'(ok), 32'd1);
        chk(name, 32'(c), 32'(exp));
    endtask

    task automatic do_reset();
        @(negedge clk_sampler);
        rst = 1'b1;
        repeat (3) @(negedge clk_sampler);
        rst = 1'b0;
    endtask

    initial begin
        logic [CW-1:0] exp_q[$];
        int bad;
        bit seen;

        bus.sampler_donesync_done  = 1'b0;
        bus.sampler_donesync_count = '0;

        tbl[0] = '{1'b1, 16'h1234, 1'b0, 1'b0, 16'h0000, 1'b1};
        tbl[1] = '{1'b0, 16'h0000, 1'b0, 1'b1, 16'h1234, 1'b1};
        tbl[2] = '{1'b0, 16'h0000, 1'b1, 1'b1, 16'h1234, 1'b1};
        tbl[3] = '{1'b0, 16'h0000, 1'b1, 1'b1, 16'h1234, 1'b1};
        tbl[4] = '{1'b0, 16'h0000, 1'b1, 1'b0, 16'h1234, 1'b1};
        tbl[5] = '{1'b0, 16'h0000, 1'b0, 1'b0, 16'h1234, 1'b1};
        tbl[6] = '{1'b0, 16'h0000, 1'b0, 1'b0, 16'h1234, 1'b1};
        tbl[7] = '{1'b0, 16'h0000, 1'b0, 1'b0, 16'h1234, 1'b0};
        tbl[8] = '{1'b1, 16'hBEEF, 1'b0, 1'b0, 16'h1234, 1'b1};
        tbl[9] = '{1'b0, 16'h0000, 1'b0, 1'b1, 16'hBEEF, 1'b1};

        repeat (2) @(negedge clk_sampler);
        chk("rst_req",      32'(bus.donesync_samplertop_req),   32'd0);
        chk("rst_count",    32'(bus.donesync_samplertop_count), 32'd0);
        chk("rst_busy",     32'(bus.donesync_sampler_busy),     32'd0);
        chk("rst_overflow", 32'(bus.donesync_sampler_overflow), 32'd0);
        @(negedge clk_sampler);
        rst = 1'b0;

        // Cycle-exact single handshake, ack driven directly
        for (int i = 0; i < 10; i++) begin
            @(negedge clk_sampler);
            bus.sampler_donesync_done  = tbl[i].done;
            bus.sampler_donesync_count = tbl[i].cnt;
            ack_man                    = tbl[i].ack;
            @(posedge clk_sampler);
            #1;
            chk($sformatf("tbl%0d_req", i),   32'(bus.donesync_samplertop_req),   32'(tbl[i].req));
            chk($sformatf("tbl%0d_count", i), 32'(bus.donesync_samplertop_count), 32'(tbl[i].ocnt));
            chk($sformatf("tbl%0d_busy", i),  32'(bus.donesync_sampler_busy),     32'(tbl[i].busy));
        end
        @(negedge clk_sampler);
        bus.sampler_donesync_done = 1'b0;
        serve_expect("tbl_beef", 16'hBEEF);
        repeat (5) @(negedge clk_sampler);
        chk("tbl_idle_busy", 32'(bus.donesync_sampler_busy), 32'd0);

        // Four back-to-back reports while ack held low
        pulse_seq(4, 16'd1);
        bad = 0;
        repeat (50) begin
            @(negedge clk_sampler);
            if (bus.donesync_samplertop_req !== 1'b1 || bus.donesync_samplertop_count !== 16'd1) bad++;
        end
        chk("b2b_hold_first", 32'(bad), 32'd0);
        for (int i = 1; i <= 4; i++) serve_expect($sformatf("b2b_deliver%0d", i), CW'(i));
        chk("b2b_overflow", 32'(bus.donesync_sampler_overflow), 32'd0);
        repeat (10) @(negedge clk_sampler);
        chk("b2b_busy", 32'(bus.donesync_sampler_busy), 32'd0);

        // Six reports with ack low: sixth is dropped
        pulse_seq(6, 16'h0011);
        repeat (20) @(negedge clk_sampler);
        chk("ovf_set", 32'(bus.donesync_sampler_overflow), 32'd1);
        for (int i = 0; i < 5; i++) serve_expect($sformatf("ovf_deliver%0d", i), 16'h0011 + CW'(i));
        bad = 0;
        repeat (50) begin
            @(negedge clk_sampler);
            if (bus.donesync_samplertop_req !== 1'b0) bad++;
        end
        chk("ovf_no_sixth", 32'(bad), 32'd0);
        chk("ovf_sticky", 32'(bus.donesync_sampler_overflow), 32'd1);
        chk("ovf_busy", 32'(bus.donesync_sampler_busy), 32'd0);

        // Reset asserted while in REQ with reports queued
        pulse_seq(3, 16'h0021);
        seen = 1'b0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk_sampler);
            if (bus.donesync_samplertop_req) begin
                seen = 1'b1;
                break;
            end
        end
        chk("rstreq_reached_req", 32'(seen), 32'd1);
        #2 rst = 1'b1;
        #1;
        chk("rstreq_req",      32'(bus.donesync_samplertop_req),   32'd0);
        chk("rstreq_busy",     32'(bus.donesync_sampler_busy),     32'd0);
        chk("rstreq_overflow", 32'(bus.donesync_sampler_overflow), 32'd0);
        repeat (2) @(negedge clk_sampler);
        rst = 1'b0;
        bad = 0;
        repeat (30) begin
            @(negedge clk_sampler);
            if (bus.donesync_samplertop_req !== 1'b0 || bus.donesync_sampler_busy !== 1'b0) bad++;
        end
        chk("rstreq_no_stale", 32'(bad), 32'd0);

        // Done coincident with an IDLE pop while the FIFO is full
        pulse_seq(5, 16'h0031);
        repeat (5) @(negedge clk_sampler);
        chk("full_first_count", 32'(bus.donesync_samplertop_count), 32'h31);
        ack_man = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk_sampler);
            if (!bus.donesync_samplertop_req) begin
                seen = 1'b1;
                break;
            end
        end
        chk("full_req_released", 32'(seen), 32'd1);
        ack_man = 1'b0;
        repeat (3) @(posedge clk_sampler);
        @(negedge clk_sampler);
        bus.sampler_donesync_done  = 1'b1;
        bus.sampler_donesync_count = 16'h0036;
        @(posedge clk_sampler);
        #1;
        chk("full_pop_req",      32'(bus.donesync_samplertop_req),   32'd1);
        chk("full_pop_count",    32'(bus.donesync_samplertop_count), 32'h32);
        chk("full_pop_overflow", 32'(bus.donesync_sampler_overflow), 32'd0);
        @(negedge clk_sampler);
        bus.sampler_donesync_done = 1'b0;
        for (int i = 0; i < 5; i++) serve_expect($sformatf("full_deliver%0d", i), 16'h0032 + CW'(i));
        repeat (10) @(negedge clk_sampler);
        chk("full_final_overflow", 32'(bus.donesync_sampler_overflow), 32'd0);
        chk("full_final_busy",     32'(bus.donesync_sampler_busy),     32'd0);

        // Ack held high through reset release
        ack_man = 1'b1;
        do_reset();
        repeat (10) @(negedge clk_sampler);
        pulse_seq(1, 16'h0041);
        bad = 0;
        repeat (20) begin
            @(negedge clk_sampler);
            if (bus.donesync_samplertop_req !== 1'b0) bad++;
        end
        chk("ackhigh_req_blocked", 32'(bad), 32'd0);
        ack_man = 1'b0;
        @(posedge clk_sampler);
        #1 chk("ackhigh_edge0_req", 32'(bus.donesync_samplertop_req), 32'd0);
        @(posedge clk_sampler);
        #1 chk("ackhigh_edge1_req", 32'(bus.donesync_samplertop_req), 32'd0);
        @(posedge clk_sampler);
        #1 chk("ackhigh_edge2_req", 32'(bus.donesync_samplertop_req), 32'd1);
        chk("ackhigh_count", 32'(bus.donesync_samplertop_count), 32'h41);
        serve_expect("ackhigh_deliver", 16'h0041);
        repeat (10) @(negedge clk_sampler);

        // Random bursts with ack looped back through the top-domain flops
        got_q.delete();
        loopback = 1'b1;
        for (int b = 0; b < 12; b++) begin
            int n;
            n = int'($urandom_range(1, 5));
            for (int k = 0; k < n; k++) begin
                int gap;
                gap = int'($urandom_range(0, 2));
                repeat (gap) @(negedge clk_sampler);
                @(negedge clk_sampler);
                bus.sampler_donesync_done  = 1'b1;
                bus.sampler_donesync_count = CW'($urandom);
                exp_q.push_back(bus.sampler_donesync_count);
                @(negedge clk_sampler);
                bus.sampler_donesync_done = 1'b0;
            end
            repeat (200) @(negedge clk_sampler);
        end
        chk("rand_delivery_count", 32'(got_q.size()), 32'(exp_q.size()));
        bad = 0;
        for (int i = 0; i < exp_q.size(); i++) begin
            if (i >= got_q.size() || got_q[i] !== exp_q[i]) bad++;
        end
        chk("rand_order_payload", 32'(bad), 32'd0);
        chk("rand_overflow", 32'(bus.donesync_sampler_overflow), 32'd0);
        chk("rand_busy",     32'(bus.donesync_sampler_busy),     32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
